m_ext_unit: RTL and testbench

- Iterative RV32M multiply/divide unit in the execute stage.
- Consumes the two source operands read from the register file and produces one 32-bit result for the EX/MEM pipeline register.
- Multi-cycle: holds the pipeline via `busy` until `done`.
- Shift-add multiplier and restoring divider share one 64-bit working register and a 6-bit iteration counter.

---
 rtl/m_ext_unit.sv | 129 ++++++++++++
 tb/tb_m_ext_unit.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/m_ext_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiplier and restoring divider on one 64-bit register.
// Latency: 33 cycles from accepted start to done (1 cycle for divide-by-zero / signed overflow).
// Backpressure: holds the pipeline with busy; start is ignored while busy, flush cancels without done.
module m_ext_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        flush,
  input  logic [2:0]  funct3,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] result
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t      state, state_nxt;
  logic [2:0]  op;
  logic [63:0] work;
  logic [31:0] opnd;
  logic [5:0]  cnt;
  logic        neg_a;
  logic        neg_diff;

  // Operand decode at issue: signedness, absolute values and the special cases.
  logic        is_div, a_sgn, b_sgn, sa, sb, div_zero, div_ovf, special, accept;
  logic [31:0] abs_a, abs_b, special_res;

  always_comb begin
    is_div   = funct3[2];
    a_sgn    = (funct3 == 3'b001) || (funct3 == 3'b010) || (funct3 == 3'b100) || (funct3 == 3'b110);
    b_sgn    = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
    sa       = a_sgn & a[31];
    sb       = b_sgn & b[31];
    abs_a    = sa ? (~a + 32'd1) : a;
    abs_b    = sb ? (~b + 32'd1) : b;
    div_zero = is_div && (b == 32'd0);
    div_ovf  = is_div && !funct3[0] && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    special  = div_zero || div_ovf;
    if (div_zero)
      special_res = funct3[1] ? a : 32'hFFFF_FFFF;
    else
      special_res = funct3[1] ? 32'd0 : 32'h8000_0000;
    accept   = (state == IDLE) && start && !flush;
  end

  // One iteration step plus the sign-corrected result of the step that ends CALC.
  logic [32:0] mul_sum;
  logic [32:0] rem_sh;
  logic [32:0] div_diff;
  logic [63:0] mul_nxt, div_nxt, work_nxt, prod;
  logic [31:0] quo, rem, fin_res;

  always_comb begin
    mul_sum  = {1'b0, work[63:32]} + (work[0] ? {1'b0, opnd} : 33'd0);
    mul_nxt  = {mul_sum, work[31:1]};
    // Shifted remainder needs 33 bits; bit 32 of the difference is the borrow.
    rem_sh   = work[63:31];
    div_diff = rem_sh - {1'b0, opnd};
    div_nxt  = div_diff[32] ? {work[62:0], 1'b0} : {div_diff[31:0], work[30:0], 1'b1};
    work_nxt = op[2] ? div_nxt : mul_nxt;
    prod     = neg_diff ? (~work_nxt + 64'd1) : work_nxt;
    quo      = neg_diff ? (~work_nxt[31:0] + 32'd1) : work_nxt[31:0];
    rem      = neg_a ? (~work_nxt[63:32] + 32'd1) : work_nxt[63:32];
    case (op)
      3'b000:         fin_res = prod[31:0];
      3'b100, 3'b101: fin_res = quo;
      3'b110, 3'b111: fin_res = rem;
      default:        fin_res = prod[63:32];
    endcase
  end

  // Next-state logic; flush wins over start and over completion.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = special ? DONE : CALC;
      CALC: begin
        if (flush)               state_nxt = IDLE;
        else if (cnt == 6'd31)   state_nxt = DONE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Datapath: operand load at issue, one bit per CALC cycle, result captured on entry to DONE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op       <= 3'd0;
      work     <= 64'd0;
      opnd     <= 32'd0;
      cnt      <= 6'd0;
      neg_a    <= 1'b0;
      neg_diff <= 1'b0;
      result   <= 32'd0;
      done     <= 1'b0;
    end else begin
      done <= (state_nxt == DONE);
      case (state)
        IDLE: if (accept) begin
          op       <= funct3;
          neg_a    <= sa;
          neg_diff <= sa ^ sb;
          cnt      <= 6'd0;
          opnd     <= is_div ? abs_b : abs_a;
          work     <= {32'd0, is_div ? abs_a : abs_b};
          if (special) result <= special_res;
        end
        CALC: if (!flush) begin
          work <= work_nxt;
          cnt  <= cnt + 6'd1;
          if (cnt == 6'd31) result <= fin_res;
        end
        default: ;
      endcase
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_m_ext_unit.sv
// Directed bench for m_ext_unit: hand-computed results, done latency and busy envelope.
// Inputs are driven 1ns after the rising edge and outputs sampled there too.
// Any wait on done is bounded; a timeout shows up as a latency mismatch.
module tb_m_ext_unit;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        flush;
  logic [2:0]  funct3;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int checks = 0;
  int errors = 0;

  m_ext_unit dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .flush  (flush),
    .funct3 (funct3),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one operation and follow it to done: latency, result, busy envelope.
  task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] va,
                        input logic [31:0] vb, input logic [31:0] exp, input int exp_lat);
    int lat;
    logic busy_ok;
    funct3 = f;
    a      = va;
    b      = vb;
    start  = 1'b1;
    step();
    start  = 1'b0;
    lat     = 0;
    busy_ok = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      if (!busy) busy_ok = 1'b0;
      if (done) begin
        lat = k;
        break;
      end
      step();
    end
    check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    check({tag, "_res"}, result, exp);
    check({tag, "_busy"}, {31'd0, busy_ok}, 32'd1);
    step();
    check({tag, "_done_drop"}, {31'd0, done}, 32'd0);
    check({tag, "_busy_drop"}, {31'd0, busy}, 32'd0);
    check({tag, "_res_hold"}, result, exp);
  endtask

  initial begin
    logic saw_done;
    logic busy_at_21;
    rst_n  = 1'b0;
    start  = 1'b0;
    flush  = 1'b0;
    funct3 = 3'd0;
    a      = 32'd0;
    b      = 32'd0;
    step();
    step();
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_res", result, 32'd0);
    rst_n = 1'b1;
    step();

    // Signed multiply with a result to prove the mid-CALC reset clears it.
    run_op("mul", 3'b000, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33);

    // Reset held for two edges in the middle of a divide.
    funct3 = 3'b100;
    a      = 32'd1000;
    b      = 32'd3;
    start  = 1'b1;
    step();
    start  = 1'b0;
    repeat (5) step();
    check("pre_rst_busy", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    step();
    step();
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_done", {31'd0, done}, 32'd0);
    check("midrst_res", result, 32'd0);
    rst_n = 1'b1;

    run_op("mulhu",  3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
    run_op("mulh",   3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33);
    run_op("mulhsu", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33);
    run_op("div_neg",  3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
    run_op("rem_neg",  3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
    run_op("divu",     3'b101, 32'd100, 32'd7, 32'd14, 33);
    run_op("remu",     3'b111, 32'd100, 32'd7, 32'd2, 33);
    run_op("div_z",    3'b100, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
    run_op("remu_z",   3'b111, 32'd5, 32'd0, 32'd5, 1);
    run_op("div_ovf",  3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    run_op("rem_ovf",  3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1);

    // Flush: DIV in flight, stray start at T+10 (a special case if honoured), flush at T+20.
    funct3 = 3'b100;
    a      = 32'd100;
    b      = 32'd7;
    start  = 1'b1;
    step();
    start      = 1'b0;
    saw_done   = 1'b0;
    busy_at_21 = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      if (done) saw_done = 1'b1;
      if (k == 21) busy_at_21 = busy;
      start = (k == 10);
      flush = (k == 20);
      if (k == 10) begin
        a = 32'd5;
        b = 32'd0;
      end
      step();
    end
    start = 1'b0;
    flush = 1'b0;
    check("flush_no_done", {31'd0, saw_done}, 32'd0);
    check("flush_idle", {31'd0, busy_at_21}, 32'd0);
    check("flush_res_kept", result, 32'd0);

    run_op("after_flush", 3'b101, 32'd100, 32'd7, 32'd14, 33);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
